// File: rtl/traffic_req_ctrl.sv
// Detector request conditioner feeding light_fsm: sync, debounce, edge latch, round-robin offer.
// Optional REQ_TIMEOUT_EN builds a stall counter that drives urgent; otherwise urgent is tied low.
module traffic_req_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor_raw,
  input  logic       req_ready,
  output logic       req_valid,
  output logic [1:0] req_dir,
  output logic [3:0] pend,
  output logic       urgent
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [3:0]    s1, s2, db, db_q;
  logic [CW-1:0] cnt [4];
  logic [3:0]    rise, clr, pend_nxt;
  state_t        state, state_nxt;
  logic          valid_nxt;
  logic [1:0]    dir_nxt, last, last_nxt, sel, idx;
  logic          found;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1   <= sensor_raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = db & ~db_q;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    valid_nxt = req_valid;
    dir_nxt   = req_dir;
    last_nxt  = last;
    clr       = '0;
    sel       = last;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (pend != 4'b0) begin
          state_nxt = OFFER;
          valid_nxt = 1'b1;
          dir_nxt   = sel;
        end
      end
      OFFER: begin
        if (req_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          clr       = 4'b0001 << req_dir;
          last_nxt  = req_dir;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new edge in the same cycle as its handshake keeps the request pending.
    pend_nxt = (pend & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_dir   <= 2'd0;
      last      <= 2'd3;
      pend      <= '0;
    end else begin
      state     <= state_nxt;
      req_valid <= valid_nxt;
      req_dir   <= dir_nxt;
      last      <= last_nxt;
      pend      <= pend_nxt;
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;

  // Counter is held at zero while idle, so it starts clean on every new offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      urgent   <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
      urgent   <= 1'b0;
    end else if (req_ready) begin
      urgent   <= 1'b0;
    end else begin
      if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WW'(MAX_WAIT - 1)) urgent <= 1'b1;
    end
  end
`else
  localparam int UNUSED_MAX_WAIT = MAX_WAIT;
  assign urgent = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_req_ctrl.sv
// Directed self-checking bench for traffic_req_ctrl (DEBOUNCE_CYCLES=4, MAX_WAIT=8).
module tb_traffic_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sensor_raw = '0;
  logic       req_ready = 1'b0;
  logic       req_valid;
  logic [1:0] req_dir;
  logic [3:0] pend;
  logic       urgent;

  int checks   = 0;
  int failures = 0;

`ifdef REQ_TIMEOUT_EN
  localparam logic URG_ON = 1'b1;
`else
  localparam logic URG_ON = 1'b0;
`endif

  traffic_req_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .req_ready(req_ready),
    .req_valid(req_valid), .req_dir(req_dir), .pend(pend), .urgent(urgent)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sensor_raw = '0;
    req_ready  = 1'b0;
    do_reset();
    checks++;
    if (req_dir !== 2'd0) begin
      $display("FAIL reset_dir got=%0d want=0", req_dir); failures++;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (pend !== 4'b0 || req_valid !== 1'b0 || urgent !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d pend=%b valid=%b urgent=%b want 0000/0/0",
                 c, pend, req_valid, urgent);
        failures++;
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    sensor_raw = 4'b0100;
    repeat (3) tick();
    sensor_raw = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (pend !== 4'b0 || req_valid !== 1'b0) begin
        $display("FAIL glitch cyc=%0d pend=%b valid=%b want 0000/0", c, pend, req_valid);
        failures++;
      end
    end
  endtask

  task automatic test_latency_hold();
    do_reset();
    sensor_raw = 4'b0010;
    repeat (6) tick();                       // after edge 5
    checks++;
    if (pend !== 4'b0) begin
      $display("FAIL lat_pend_early got=%b want=0000", pend); failures++;
    end
    tick();                                  // after edge 6
    checks++;
    if (pend !== 4'b0010 || req_valid !== 1'b0) begin
      $display("FAIL lat_pend got=%b valid=%b want 0010/0", pend, req_valid); failures++;
    end
    tick();                                  // after edge 7
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd1) begin
      $display("FAIL lat_offer valid=%b dir=%0d want 1/1", req_valid, req_dir); failures++;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (req_valid !== 1'b1 || req_dir !== 2'd1 || pend !== 4'b0010 || urgent !== 1'b0) begin
        $display("FAIL hold cyc=%0d valid=%b dir=%0d pend=%b urgent=%b want 1/1/0010/0",
                 c, req_valid, req_dir, pend, urgent);
        failures++;
      end
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++;
    if (pend !== 4'b0 || req_valid !== 1'b0) begin
      $display("FAIL handshake pend=%b valid=%b want 0000/0", pend, req_valid); failures++;
    end
    repeat (3) tick();
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0) begin
      $display("FAIL held_no_reoffer valid=%b pend=%b want 0/0000", req_valid, pend); failures++;
    end
    sensor_raw = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pend;
    do_reset();
    req_ready  = 1'b1;
    sensor_raw = 4'b1111;
    repeat (7) tick();
    checks++;
    if (pend !== 4'b1111) begin
      $display("FAIL rr_pend got=%b want=1111", pend); failures++;
    end
    exp_pend = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (req_valid !== 1'b1 || req_dir !== 2'(i)) begin
        $display("FAIL rr_offer idx=%0d valid=%b dir=%0d want 1/%0d", i, req_valid, req_dir, i);
        failures++;
      end
      tick();
      exp_pend[i] = 1'b0;
      checks++;
      if (req_valid !== 1'b0 || pend !== exp_pend) begin
        $display("FAIL rr_gap idx=%0d valid=%b pend=%b want 0/%b", i, req_valid, pend, exp_pend);
        failures++;
      end
    end
    sensor_raw = 4'b0000;
    repeat (10) tick();
    checks++;
    if (pend !== 4'b0 || req_valid !== 1'b0) begin
      $display("FAIL rr_fall pend=%b valid=%b want 0000/0", pend, req_valid); failures++;
    end
    sensor_raw = 4'b0101;
    repeat (7) tick();
    checks++;
    if (pend !== 4'b0101) begin
      $display("FAIL rr2_pend got=%b want=0101", pend); failures++;
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd0) begin
      $display("FAIL rr2_first valid=%b dir=%0d want 1/0", req_valid, req_dir); failures++;
    end
    tick();
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0100) begin
      $display("FAIL rr2_gap valid=%b pend=%b want 0/0100", req_valid, pend); failures++;
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd2) begin
      $display("FAIL rr2_second valid=%b dir=%0d want 1/2", req_valid, req_dir); failures++;
    end
    tick();
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0000) begin
      $display("FAIL rr2_done valid=%b pend=%b want 0/0000", req_valid, pend); failures++;
    end
    req_ready  = 1'b0;
    sensor_raw = 4'b0000;
  endtask

  task automatic test_timeout();
    logic exp_u;
    do_reset();
    sensor_raw = 4'b1000;
    repeat (8) tick();
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd3 || urgent !== 1'b0) begin
      $display("FAIL to_offer valid=%b dir=%0d urgent=%b want 1/3/0", req_valid, req_dir, urgent);
      failures++;
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_u = (i >= 8) ? URG_ON : 1'b0;
      checks++;
      if (urgent !== exp_u || req_valid !== 1'b1) begin
        $display("FAIL to_stall n=%0d urgent=%b valid=%b want %b/1", i, urgent, req_valid, exp_u);
        failures++;
      end
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    checks++;
    if (urgent !== 1'b0 || req_valid !== 1'b0 || pend !== 4'b0) begin
      $display("FAIL to_clear urgent=%b valid=%b pend=%b want 0/0/0000", urgent, req_valid, pend);
      failures++;
    end
    sensor_raw = 4'b0000;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    sensor_raw = 4'b0001;
    repeat (8) tick();
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd0) begin
      $display("FAIL mid_offer valid=%b dir=%0d want 1/0", req_valid, req_dir); failures++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0) begin
      $display("FAIL mid_reset valid=%b pend=%b want 0/0000", req_valid, pend); failures++;
    end
    repeat (7) tick();                       // after edge 6
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0001) begin
      $display("FAIL mid_repend valid=%b pend=%b want 0/0001", req_valid, pend); failures++;
    end
    tick();                                  // after edge 7
    checks++;
    if (req_valid !== 1'b1 || req_dir !== 2'd0) begin
      $display("FAIL mid_reoffer valid=%b dir=%0d want 1/0", req_valid, req_dir); failures++;
    end
    sensor_raw = 4'b0000;
  endtask

  initial begin
    tick();
    test_reset();
    test_glitch();
    test_latency_hold();
    test_round_robin();
    test_timeout();
    test_reset_mid_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
